// File: rtl/ifu_fetch_ctrl_if.sv
// Fetch controller bus bundle: instruction-memory request/response channel and
// the push/occupancy side of the downstream IF/ID fifo.
interface ifu_fetch_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                             mem_req;
  logic [ADDR_WIDTH-1:0]            mem_addr;
  logic                             mem_gnt;
  logic                             mem_rvalid;
  logic [DATA_WIDTH-1:0]            mem_rdata;
  logic                             fifo_w_req;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] fifo_wdata;
  logic                             fifo_full;
  logic                             fifo_pop;

  modport master (
    output mem_req, mem_addr, fifo_w_req, fifo_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata, fifo_full, fifo_pop
  );

  modport slave (
    input  mem_req, mem_addr, fifo_w_req, fifo_wdata,
    output mem_gnt, mem_rvalid, mem_rdata, fifo_full, fifo_pop
  );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// Sequential instruction fetch with credit-based fifo flow control and flush/drain.
// Optional IFU_MISALIGN_CHECK_EN: misaligned redirect target halts fetch (fetch_misalign).
module ifu_fetch_ctrl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2,
  parameter int                    CNT_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_pc,
  input  logic                  hold,
`ifdef IFU_MISALIGN_CHECK_EN
  output logic                  fetch_misalign,
`endif
  ifu_fetch_ctrl_if.master      bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALT} state_t;

  localparam logic [CNT_WIDTH:0]    DEPTH_C = (CNT_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0]  ONE_C   = CNT_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] STEP_C  = ADDR_WIDTH'(4);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
  logic [ADDR_WIDTH-1:0] rsp_pc_reg, rsp_pc_next;
  logic [CNT_WIDTH-1:0]  outst_reg, outst_next;
  logic [CNT_WIDTH-1:0]  occ_reg, occ_next;
  logic [CNT_WIDTH-1:0]  drop_reg, drop_next;
  logic                  req_hold_reg, req_hold_next;
  logic                  misalign_reg, misalign_next;

  logic [ADDR_WIDTH-1:0] flush_target;
  logic                  misalign_flush;
  logic                  credit_ok;
  logic                  mem_req_c;
  logic                  req_fire;
  logic                  push;
  logic                  unused_full;

  assign flush_target = {flush_pc[ADDR_WIDTH-1:2], 2'b00};
  assign unused_full  = bus.fifo_full;

`ifdef IFU_MISALIGN_CHECK_EN
  assign misalign_flush = flush & (flush_pc[1:0] != 2'b00);
  assign fetch_misalign = misalign_reg;
`else
  logic unused_bits;
  assign misalign_flush = 1'b0;
  assign unused_bits    = ^{flush_pc[1:0], misalign_reg};
`endif

  // Responses already promised (outstanding) count against fifo space, so a push never overflows.
  assign credit_ok = ({1'b0, outst_reg} + {1'b0, occ_reg}) < DEPTH_C;
  assign mem_req_c = (state_reg == FETCH) & (req_hold_reg | (~hold & credit_ok));
  assign req_fire  = mem_req_c & bus.mem_gnt;
  assign push      = bus.mem_rvalid & (state_reg == FETCH) & ~flush;

  assign bus.mem_req    = mem_req_c;
  assign bus.mem_addr   = pc_reg;
  assign bus.fifo_w_req = push;
  assign bus.fifo_wdata = {rsp_pc_reg, bus.mem_rdata};

  always_comb begin
    outst_next = outst_reg;
    if (req_fire & ~bus.mem_rvalid) begin
      outst_next = outst_reg + ONE_C;
    end else if (~req_fire & bus.mem_rvalid) begin
      outst_next = outst_reg - ONE_C;
    end
  end

  always_comb begin
    occ_next = occ_reg;
    if (flush && state_reg == FETCH) begin
      occ_next = '0;
    end else if (push & ~bus.fifo_pop) begin
      occ_next = occ_reg + ONE_C;
    end else if (~push & bus.fifo_pop) begin
      occ_next = occ_reg - ONE_C;
    end
  end

  // An offered but ungranted request is latched so it stays up regardless of hold/credits.
  assign req_hold_next = mem_req_c & ~bus.mem_gnt & ~flush;

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    rsp_pc_next   = rsp_pc_reg;
    drop_next     = drop_reg;
    misalign_next = misalign_reg;

    case (state_reg)
      IDLE:  state_next = FETCH;
      FETCH: begin
        if (req_fire) begin
          pc_next = pc_reg + STEP_C;
        end
      end
      DRAIN: begin
        if (bus.mem_rvalid) begin
          drop_next = drop_reg - ONE_C;
        end
        if (drop_next == '0) begin
          state_next = FETCH;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase

    if (push) begin
      rsp_pc_next = rsp_pc_reg + STEP_C;
    end

    // A redirect in DRAIN only retargets; the stale-response count keeps running down.
    if (flush && state_reg != IDLE) begin
      pc_next     = flush_target;
      rsp_pc_next = flush_target;
      if (misalign_flush) begin
        misalign_next = 1'b1;
        state_next    = HALT;
      end else if (state_reg != DRAIN) begin
        misalign_next = 1'b0;
        drop_next     = outst_next;
        state_next    = (outst_next != '0) ? DRAIN : FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC;
      rsp_pc_reg   <= RESET_PC;
      outst_reg    <= '0;
      occ_reg      <= '0;
      drop_reg     <= '0;
      req_hold_reg <= 1'b0;
      misalign_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      rsp_pc_reg   <= rsp_pc_next;
      outst_reg    <= outst_next;
      occ_reg      <= occ_next;
      drop_reg     <= drop_next;
      req_hold_reg <= req_hold_next;
      misalign_reg <= misalign_next;
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed + randomized bench for ifu_fetch_ctrl against a queue-based fetch/fifo model.
module tb_ifu_fetch_ctrl;
  localparam int          AW     = 32;
  localparam int          DW     = 32;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0;

  typedef struct {
    logic [31:0] pc;
    bit          stale;
    int          gcyc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        hold = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  ifu_fetch_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ifu_fetch_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .flush_pc(flush_pc),
    .hold(hold),
`ifdef IFU_MISALIGN_CHECK_EN
    .fetch_misalign(fetch_misalign),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  ent_t        q[$];
  int          occ = 0;
  int          stale = 0;
  bit          pend = 0;
  bit          halted = 0;
  logic [31:0] pc_m = RST_PC;
  bit          d_gnt, d_rv, d_pop, d_hold, d_flush;
  logic [31:0] d_fpc;
  bit          o_req, o_push;
  logic [31:0] o_addr;
  logic [63:0] o_wd;
  int          n_gnt, n_push;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic bound_chk(input string tag, input int used, input int limit);
    total++;
    assert (used < limit) else begin
      bad++;
      $error("FAIL %s timeout observed=%0d cycles expected<%0d", tag, used, limit);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
    bus.fifo_pop = 0; bus.fifo_full = 0;
    hold = 0; flush = 0; flush_pc = '0;
    d_gnt = 0; d_rv = 0; d_pop = 0; d_hold = 0; d_flush = 0; d_fpc = '0;
    q.delete(); occ = 0; stale = 0; pend = 0; halted = 0; pc_m = RST_PC;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, RST_PC);
    chk("rst_w_req", bus.fifo_w_req, 0);
`ifdef IFU_MISALIGN_CHECK_EN
    chk("rst_misalign", fetch_misalign, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_mem_req", bus.mem_req, 0);
    cyc++;
  endtask

  // One cycle: drive at negedge, check combinational outputs, advance the model.
  task automatic tick();
    bit          rv, pop, exp_req, exp_push, fire;
    logic [63:0] exp_wd;
    ent_t        e;
    @(negedge clk);
    rv  = d_rv && q.size() > 0 && q[0].gcyc < cyc;
    pop = d_pop && occ > 0;
    bus.mem_gnt    = d_gnt;
    bus.mem_rvalid = rv;
    bus.mem_rdata  = rv ? mem_f(q[0].pc) : 32'($urandom);
    bus.fifo_pop   = pop;
    bus.fifo_full  = (occ == DEPTH);
    hold = d_hold; flush = d_flush; flush_pc = d_fpc;
    #1;
`ifdef IFU_MISALIGN_CHECK_EN
    chk("fetch_misalign", fetch_misalign, halted);
`endif
    if (pend) exp_req = 1;
    else if (halted || stale > 0) exp_req = 0;
    else exp_req = !d_hold && (q.size() + occ < DEPTH);
    chk("mem_req", bus.mem_req, exp_req);
    if (exp_req) chk("mem_addr", bus.mem_addr, pc_m);
    exp_push = 0;
    exp_wd = '0;
    if (rv) begin
      e = q.pop_front();
      if (e.stale) stale--;
      else if (!d_flush && !halted) begin
        exp_push = 1;
        exp_wd = {e.pc, mem_f(e.pc)};
      end
    end
    chk("fifo_w_req", bus.fifo_w_req, exp_push);
    if (exp_push) chk("fifo_wdata", bus.fifo_wdata, exp_wd);
    chk("push_while_full", bus.fifo_w_req & bus.fifo_full, 0);
    o_req = bus.mem_req; o_addr = bus.mem_addr; o_push = bus.fifo_w_req; o_wd = bus.fifo_wdata;
    if (bus.mem_req && d_gnt) n_gnt++;
    if (bus.fifo_w_req) n_push++;
    fire = exp_req && d_gnt;
    if (fire) begin
      q.push_back('{pc: pc_m, stale: 1'b0, gcyc: cyc});
      pc_m = pc_m + 32'd4;
    end
    pend = exp_req && !d_gnt && !d_flush;
    if (exp_push) occ++;
    if (pop) occ--;
    if (d_flush) begin
      occ = 0;
      pc_m = d_fpc & 32'hFFFF_FFFC;
      foreach (q[i]) q[i].stale = 1;
      stale = q.size();
`ifdef IFU_MISALIGN_CHECK_EN
      halted = (d_fpc[1:0] != 2'b00);
`endif
    end
    cyc++;
  endtask

  initial begin
    logic [31:0] pcs[$];
    int guard;

    // 1: free-running fetch with immediate grant/response and continuous pop
    apply_reset();
    d_gnt = 1; d_rv = 1; d_pop = 1;
    tick();
    chk("t1_first_req", o_req, 1);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (o_push) pcs.push_back(o_wd[63:32]);
    end
    for (int i = 0; i < 5; i++)
      chk("t1_push_pc", (i < pcs.size()) ? pcs[i] : 32'hDEADBEEF, 32'(i * 4));

    // 2: no pop -> credits stop fetch after DEPTH grants; one pop -> one request
    d_gnt = 0;
    guard = 0;
    while ((q.size() != 0 || occ != 0) && guard < 30) begin tick(); guard++; end
    bound_chk("t2_drain", guard, 30);
    d_gnt = 1; d_pop = 0; n_gnt = 0; n_push = 0;
    repeat (10) tick();
    chk("t2_grants", n_gnt, 2);
    chk("t2_pushes", n_push, 2);
    chk("t2_stalled", o_req, 0);
    n_gnt = 0;
    d_pop = 1; tick(); d_pop = 0;
    repeat (6) tick();
    chk("t2_one_more", n_gnt, 1);

    // 3: ungranted request stays stable while hold toggles
    d_gnt = 0; d_pop = 1; tick(); d_pop = 0;
    n_gnt = 0;
    for (int i = 0; i < 4; i++) begin d_hold = (i % 2 == 1); tick(); end
    chk("t3_req_held", o_req, 1);
    d_hold = 1; d_gnt = 1;
    repeat (3) tick();
    chk("t3_grants", n_gnt, 1);
    d_hold = 0;

    // 4: flush with two responses outstanding
    d_gnt = 1; d_rv = 0; d_pop = 1;
    guard = 0;
    while (q.size() != 2 && guard < 20) begin tick(); guard++; end
    bound_chk("t4_fill", guard, 20);
    d_flush = 1; d_fpc = 32'h100; d_gnt = 0;
    tick();
    d_flush = 0; d_rv = 1; d_gnt = 1; n_push = 0;
    guard = 0;
    do begin tick(); guard++; end while (!o_req && guard < 20);
    bound_chk("t4_restart", guard, 20);
    chk("t4_dropped", n_push, 0);
    chk("t4_addr", o_addr, 32'h100);
    guard = 0;
    do begin tick(); guard++; end while (!o_push && guard < 20);
    bound_chk("t4_push_wait", guard, 20);
    chk("t4_push_pc", o_wd[63:32], 32'h100);

    // 5: async reset while draining
    d_gnt = 1; d_rv = 0; d_pop = 1;
    guard = 0;
    while (q.size() != 2 && guard < 20) begin tick(); guard++; end
    bound_chk("t5_fill", guard, 20);
    d_flush = 1; d_fpc = 32'h300; d_gnt = 0;
    tick();
    d_flush = 0;
    tick();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_req", bus.mem_req, 0);
    chk("t5_async_addr", bus.mem_addr, RST_PC);
    chk("t5_async_w_req", bus.fifo_w_req, 0);
    apply_reset();
    d_gnt = 1; d_rv = 1; d_pop = 1;
    tick();
    chk("t5_restart_addr", o_addr, RST_PC);
    repeat (6) tick();

    // randomized traffic with occasional redirects
    for (int i = 0; i < 800; i++) begin
      d_gnt = ($urandom_range(0, 3) != 0);
      d_rv = ($urandom_range(0, 2) != 0);
      d_pop = ($urandom_range(0, 1) != 0);
      d_hold = ($urandom_range(0, 4) == 0);
      d_flush = ($urandom_range(0, 24) == 0);
      d_fpc = 32'($urandom);
`ifdef IFU_MISALIGN_CHECK_EN
      if ($urandom_range(0, 3) != 0) d_fpc[1:0] = 2'b00;
`endif
      tick();
    end
    d_flush = 1; d_fpc = 32'h40; d_hold = 0;
    tick();
    d_flush = 0; d_gnt = 1; d_rv = 1; d_pop = 1;
    repeat (20) tick();

`ifdef IFU_MISALIGN_CHECK_EN
    // 6: misaligned redirect halts, aligned redirect resumes
    d_flush = 1; d_fpc = 32'h102;
    tick();
    d_flush = 0;
    tick();
    chk("t6_misalign", fetch_misalign, 1);
    chk("t6_no_req", o_req, 0);
    repeat (5) tick();
    d_flush = 1; d_fpc = 32'h200;
    tick();
    d_flush = 0;
    guard = 0;
    do begin tick(); guard++; end while (!o_req && guard < 20);
    bound_chk("t6_restart", guard, 20);
    chk("t6_addr", o_addr, 32'h200);
    chk("t6_cleared", fetch_misalign, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
